irq_arbiter: RTL and testbench

- Machine-level external interrupt controller (PLIC-lite). It feeds the single `interrupt` input of the exception unit.
- Latches edge events from NSRC peripheral sources into pending bits and masks them with a software enable register.
- Arbitrates by fixed priority (lowest index wins) and sequences each interrupt through request, claim and complete.
- Software in the trap handler accesses it through a small word-addressed register port on the data-memory bus.

---
 rtl/irq_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_irq_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/irq_arbiter.sv
// Fixed-priority external interrupt controller with request/claim/complete sequencing.
// Define IRQ_ARBITER_MTIMER_EN to add a 64-bit machine timer as source id 31.
module irq_arbiter #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] irq_src,
    input  logic            mie,
    input  logic            trap_taken,
    input  logic            bus_re,
    input  logic            bus_we,
    input  logic [4:0]      bus_addr,
    input  logic [31:0]     bus_wdata,
    output logic [31:0]     bus_rdata,
    output logic            interrupt,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        REQ        = 2'd1,
        WAIT_CLAIM = 2'd2,
        SERVICE    = 2'd3
    } state_t;

    localparam logic [2:0] A_PENDING    = 3'd0;
    localparam logic [2:0] A_ENABLE     = 3'd1;
    localparam logic [2:0] A_CLAIM      = 3'd2;
    localparam logic [2:0] A_COMPLETE   = 3'd3;
    localparam logic [2:0] A_MTIME_LO   = 3'd4;
    localparam logic [2:0] A_MTIME_HI   = 3'd5;
    localparam logic [2:0] A_MTCMP_LO   = 3'd6;
    localparam logic [2:0] A_MTCMP_HI   = 3'd7;
    localparam logic [4:0] TIMER_ID     = 5'd31;

    state_t          state_reg;
    logic [NSRC-1:0] prev_src_reg;
    logic [NSRC-1:0] pending_reg;
    logic [NSRC-1:0] pending_next;
    logic [NSRC-1:0] enable_reg;
    logic [4:0]      in_service_reg;
    logic [31:0]     bus_rdata_reg;
    logic [31:0]     rdata_next;

    logic [2:0]      word_addr;
    logic            claim_rd;
    logic            complete_wr;
    logic            enable_wr;
    logic [4:0]      ext_id;
    logic [4:0]      win_id;
    logic            timer_pend;
    logic [NSRC-1:0] src_rise;
    logic [NSRC-1:0] claim_clr;
    logic            unused_bits;

    assign word_addr   = bus_addr[4:2];
    assign claim_rd    = bus_re && (word_addr == A_CLAIM);
    assign complete_wr = bus_we && (word_addr == A_COMPLETE);
    assign enable_wr   = bus_we && (word_addr == A_ENABLE);
    assign unused_bits = &{1'b0, bus_addr[1:0], bus_wdata};

    // Lowest enabled pending source wins among the external lines.
    always_comb begin
        ext_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_reg[i] && enable_reg[i]) begin
                ext_id = 5'(i + 1);
            end
        end
    end

    assign win_id = timer_pend ? TIMER_ID : ext_id;

    // Claim clears only the external winner; a new edge in the same cycle keeps the bit set.
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
        assign src_rise[gi]     = irq_src[gi] & ~prev_src_reg[gi];
        assign claim_clr[gi]    = claim_rd && !timer_pend && (ext_id == 5'(gi + 1));
        assign pending_next[gi] = src_rise[gi] | (pending_reg[gi] & ~claim_clr[gi]);
    end

`ifdef IRQ_ARBITER_MTIMER_EN
    logic [63:0] mtime_reg;
    logic [63:0] mtimecmp_reg;

    assign timer_pend = (mtime_reg >= mtimecmp_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
        end else begin
            if (bus_we && word_addr == A_MTIME_LO) begin
                mtime_reg <= {mtime_reg[63:32], bus_wdata};
            end else if (bus_we && word_addr == A_MTIME_HI) begin
                mtime_reg <= {bus_wdata, mtime_reg[31:0]};
            end else begin
                mtime_reg <= mtime_reg + 64'd1;
            end
            if (bus_we && word_addr == A_MTCMP_LO) begin
                mtimecmp_reg[31:0] <= bus_wdata;
            end
            if (bus_we && word_addr == A_MTCMP_HI) begin
                mtimecmp_reg[63:32] <= bus_wdata;
            end
        end
    end
`else
    assign timer_pend = 1'b0;
`endif

    // Read data reflects state before any same-cycle write.
    always_comb begin
        rdata_next = '0;
        case (word_addr)
            A_PENDING:  rdata_next = 32'(pending_reg);
            A_ENABLE:   rdata_next = 32'(enable_reg);
            A_CLAIM:    rdata_next = 32'(win_id);
            A_COMPLETE: rdata_next = 32'(in_service_reg);
`ifdef IRQ_ARBITER_MTIMER_EN
            A_MTIME_LO: rdata_next = mtime_reg[31:0];
            A_MTIME_HI: rdata_next = mtime_reg[63:32];
            A_MTCMP_LO: rdata_next = mtimecmp_reg[31:0];
            A_MTCMP_HI: rdata_next = mtimecmp_reg[63:32];
`endif
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            prev_src_reg   <= '0;
            pending_reg    <= '0;
            enable_reg     <= '0;
            in_service_reg <= '0;
            bus_rdata_reg  <= '0;
        end else begin
            prev_src_reg <= irq_src;
            pending_reg  <= pending_next;
            if (enable_wr) begin
                enable_reg <= bus_wdata[NSRC-1:0];
            end
            if (bus_re) begin
                bus_rdata_reg <= rdata_next;
            end
            case (state_reg)
                IDLE: begin
                    if (mie && win_id != 5'd0) begin
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (trap_taken) begin
                        state_reg <= WAIT_CLAIM;
                    end else if (win_id == 5'd0 || !mie) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT_CLAIM: begin
                    if (claim_rd) begin
                        if (win_id != 5'd0) begin
                            state_reg      <= SERVICE;
                            in_service_reg <= win_id;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                SERVICE: begin
                    if (complete_wr && bus_wdata[4:0] == in_service_reg) begin
                        state_reg      <= IDLE;
                        in_service_reg <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus_rdata = bus_rdata_reg;
    assign interrupt = (state_reg == REQ);
    assign busy      = (state_reg == SERVICE);

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed self-checking bench for irq_arbiter (default build, NSRC=8).
module tb_irq_arbiter;

    localparam int NSRC = 8;
    localparam logic [4:0] R_PENDING  = 5'h00;
    localparam logic [4:0] R_ENABLE   = 5'h04;
    localparam logic [4:0] R_CLAIM    = 5'h08;
    localparam logic [4:0] R_COMPLETE = 5'h0C;

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] irq_src;
    logic            mie;
    logic            trap_taken;
    logic            bus_re;
    logic            bus_we;
    logic [4:0]      bus_addr;
    logic [31:0]     bus_wdata;
    logic [31:0]     bus_rdata;
    logic            interrupt;
    logic            busy;

    int tests_run = 0;
    int tests_failed = 0;

    irq_arbiter #(.NSRC(NSRC)) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .mie        (mie),
        .trap_taken (trap_taken),
        .bus_re     (bus_re),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .interrupt  (interrupt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) begin
            $display("[TB] %s obs=%0h exp=%0h ok", tag, obs, exp);
        end else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [4:0] a);
        bus_re   = 1'b1;
        bus_addr = a;
        step();
        bus_re   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus_we    = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        step();
        bus_we    = 1'b0;
    endtask

    task automatic pulse_trap();
        trap_taken = 1'b1;
        step();
        trap_taken = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = '0; mie = 1'b0; trap_taken = 1'b0;
        bus_re = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        step(3);
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdata", bus_rdata, 32'd0);
        rst = 1'b0;

        // Single source 2 through the full request/claim/complete sequence
        wr(R_ENABLE, 32'h04);
        rd(R_ENABLE);
        chk("enable_rd", bus_rdata, 32'h04);
        mie = 1'b1;
        irq_src = 8'h04;
        step();
        chk("t1_int_early", 32'(interrupt), 32'd0);
        step();
        chk("t1_int_req", 32'(interrupt), 32'd1);
        rd(R_PENDING);
        chk("t1_pending", bus_rdata, 32'h04);
        chk("t1_int_hold", 32'(interrupt), 32'd1);
        pulse_trap();
        chk("t1_int_after_trap", 32'(interrupt), 32'd0);
        chk("t1_busy_wait", 32'(busy), 32'd0);
        rd(R_CLAIM);
        chk("t1_claim", bus_rdata, 32'd3);
        chk("t1_busy_svc", 32'(busy), 32'd1);
        rd(R_PENDING);
        chk("t1_pending_clr", bus_rdata, 32'd0);
        rd(R_COMPLETE);
        chk("t1_in_service", bus_rdata, 32'd3);
        wr(R_COMPLETE, 32'd3);
        chk("t1_busy_done", 32'(busy), 32'd0);
        chk("t1_int_done", 32'(interrupt), 32'd0);
        irq_src = '0;

        // Simultaneous edges on sources 5 and 1: lower index first
        wr(R_ENABLE, 32'hFF);
        irq_src = 8'h22;
        step(2);
        chk("t2_int_req", 32'(interrupt), 32'd1);
        pulse_trap();
        rd(R_CLAIM);
        chk("t2_claim_first", bus_rdata, 32'd2);
        wr(R_COMPLETE, 32'd2);
        chk("t2_int_idle", 32'(interrupt), 32'd0);
        step();
        chk("t2_int_again", 32'(interrupt), 32'd1);
        pulse_trap();
        rd(R_CLAIM);
        chk("t2_claim_second", bus_rdata, 32'd6);
        wr(R_COMPLETE, 32'd6);
        chk("t2_busy_done", 32'(busy), 32'd0);
        irq_src = '0;

        // Enable cleared while requesting: request drops, pending kept
        irq_src = 8'h01;
        step(2);
        chk("t3_int_req", 32'(interrupt), 32'd1);
        wr(R_ENABLE, 32'h00);
        step();
        chk("t3_int_drop", 32'(interrupt), 32'd0);
        chk("t3_busy", 32'(busy), 32'd0);
        rd(R_PENDING);
        chk("t3_pending_kept", bus_rdata, 32'h01);
        step(3);
        chk("t3_int_stays_low", 32'(interrupt), 32'd0);

        // Read and write ENABLE together returns the old value
        bus_re = 1'b1; bus_we = 1'b1; bus_addr = R_ENABLE; bus_wdata = 32'h04;
        step();
        bus_re = 1'b0; bus_we = 1'b0;
        chk("rw_old_value", bus_rdata, 32'h00);
        rd(5'h06);
        chk("addr_low_bits_ignored", bus_rdata, 32'h04);

        // Mismatched COMPLETE is ignored
        irq_src = 8'h05;
        step(2);
        pulse_trap();
        rd(R_CLAIM);
        chk("t4_claim", bus_rdata, 32'd3);
        chk("t4_busy", 32'(busy), 32'd1);
        wr(R_COMPLETE, 32'd4);
        chk("t4_busy_mismatch", 32'(busy), 32'd1);
        rd(R_COMPLETE);
        chk("t4_in_service", bus_rdata, 32'd3);
        wr(R_COMPLETE, 32'd3);
        chk("t4_busy_done", 32'(busy), 32'd0);

        // CLAIM in the same cycle as a new edge on the winner: set wins
        irq_src = 8'h01;
        step();
        irq_src = 8'h05;
        step(2);
        chk("t5_int_req", 32'(interrupt), 32'd1);
        pulse_trap();
        irq_src = 8'h01;
        step();
        irq_src = 8'h05;
        rd(R_CLAIM);
        chk("t5_claim", bus_rdata, 32'd3);
        chk("t5_busy", 32'(busy), 32'd1);
        rd(R_PENDING);
        chk("t5_pending_set_wins", bus_rdata, 32'h05);
        wr(R_COMPLETE, 32'd3);
        chk("t5_busy_done", 32'(busy), 32'd0);
        step();
        chk("t5_rerequest", 32'(interrupt), 32'd1);

        // Dropping mie while requesting returns to IDLE
        mie = 1'b0;
        step();
        chk("mie_drop", 32'(interrupt), 32'd0);
        wr(R_PENDING, 32'h00);
        rd(R_PENDING);
        chk("pending_ro", bus_rdata, 32'h05);

`ifndef IRQ_ARBITER_MTIMER_EN
        rd(5'h10);
        chk("unmapped_read", bus_rdata, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
